voice_env_mixer: RTL and testbench

Sits between the four-voice sample generator and the 8-bit PWM audio stage. Applies a per-voice attack/release amplitude envelope driven by gate and note-on strobes from the note sequencer. Mixes the scaled voices into one offset-binary 8-bit sample for the PWM stage. Mixing is time-multiplexed, one voice per clock, so a single multiplier serves all voices.

---
 rtl/voice_env_mixer_if.sv | 21 ++
 rtl/voice_env_mixer.sv | 188 ++++++++++++++++++
 tb/tb_voice_env_mixer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_env_mixer_if.sv
// Voice mixer bus: per-voice samples, gate/note_on strobes in, mixed
// offset-binary sample and its valid pulse out.
interface voice_env_mixer_if #(
    parameter int NUM_VOICES = 4
);
    logic [8*NUM_VOICES-1:0] sample_in;
    logic [NUM_VOICES-1:0]   gate;
    logic [NUM_VOICES-1:0]   note_on;
    logic [7:0]              mix_out;
    logic                    mix_valid;

    modport master (
        output sample_in, gate, note_on,
        input  mix_out, mix_valid
    );

    modport slave (
        input  sample_in, gate, note_on,
        output mix_out, mix_valid
    );
endinterface

// File: rtl/voice_env_mixer.sv
// Per-voice attack/release envelope plus time-multiplexed 8-bit mixer.
// Optional MIX_DITHER_EN adds a 2-bit LFSR dither before the final >>>2.
module voice_env_mixer #(
    parameter int NUM_VOICES    = 4,
    parameter int TICK_DIV      = 30000,
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 3
) (
    input logic clk,
    input logic rst_n,
    voice_env_mixer_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int AW = 9 + PW;

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(NUM_VOICES - 1);
    localparam logic signed [AW-1:0] MAXV = AW'(127);
    localparam logic signed [AW-1:0] MINV = -AW'(128);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_SUSTAIN,
        ST_RELEASE
    } env_e;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tick_w;
    logic [NUM_VOICES-1:0] pend_q, pend_d, take_w;
    logic [7:0]            lvl_q [NUM_VOICES];
    logic [7:0]            lvl_d [NUM_VOICES];
    env_e                  st_q  [NUM_VOICES];
    env_e                  st_d  [NUM_VOICES];

    logic [PW-1:0]          phase_q, phase_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [8:0]      s_w;
    logic signed [17:0]     prod_w;
    logic signed [9:0]      sc_w;
    logic [7:0]             frac_unused;
    logic signed [AW-1:0]   tot_w, sh_w;
    logic [7:0]             out_w;
    logic [7:0]             mix_q, mix_d;
    logic                   vld_q, vld_d;

    function automatic logic [7:0] att_step(input logic [7:0] l);
        logic [8:0] s;
        s = {1'b0, l} + {1'b0, (8'hFF - l) >> ATTACK_SHIFT} + 9'd1;
        return (s >= 9'd255) ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] rel_step(input logic [7:0] l);
        logic [8:0] d;
        d = {1'b0, l >> RELEASE_SHIFT} + 9'd1;
        return ({1'b0, l} <= d) ? 8'h00 : (l - d[7:0]);
    endfunction

    assign tick_w = (cnt_q == TICK_LAST);
    assign cnt_d  = tick_w ? '0 : cnt_q + 1'b1;
    assign take_w = pend_q | bus.note_on;
    assign pend_d = tick_w ? '0 : take_w;

    // Envelope next-state: only moves on tick; retrigger beats gate rules.
    always_comb begin
        logic [7:0] n;
        for (int v = 0; v < NUM_VOICES; v++) begin
            lvl_d[v] = lvl_q[v];
            st_d[v]  = st_q[v];
            n        = 8'h00;
            if (tick_w) begin
                if (take_w[v] && bus.gate[v]) begin
                    lvl_d[v] = lvl_q[v] >> 1;
                    st_d[v]  = ST_ATTACK;
                end else begin
                    unique case (st_q[v])
                        ST_IDLE: begin
                            lvl_d[v] = 8'h00;
                            if (bus.gate[v]) begin
                                n        = att_step(8'h00);
                                lvl_d[v] = n;
                                st_d[v]  = (n == 8'hFF) ? ST_SUSTAIN
                                                        : ST_ATTACK;
                            end
                        end
                        ST_ATTACK: begin
                            if (!bus.gate[v]) begin
                                st_d[v] = ST_RELEASE;
                            end else begin
                                n        = att_step(lvl_q[v]);
                                lvl_d[v] = n;
                                if (n == 8'hFF) st_d[v] = ST_SUSTAIN;
                            end
                        end
                        ST_SUSTAIN: begin
                            lvl_d[v] = 8'hFF;
                            if (!bus.gate[v]) begin
                                n        = rel_step(8'hFF);
                                lvl_d[v] = n;
                                st_d[v]  = (n == 8'h00) ? ST_IDLE
                                                        : ST_RELEASE;
                            end
                        end
                        ST_RELEASE: begin
                            if (bus.gate[v]) begin
                                st_d[v] = ST_ATTACK;
                            end else begin
                                n        = rel_step(lvl_q[v]);
                                lvl_d[v] = n;
                                if (n == 8'h00) st_d[v] = ST_IDLE;
                            end
                        end
                        default: begin
                            lvl_d[v] = 8'h00;
                            st_d[v]  = ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign s_w    = $signed({1'b0, bus.sample_in[{phase_q, 3'b000} +: 8]})
                  - 9'sd128;
    assign prod_w = s_w * $signed({1'b0, lvl_q[phase_q]});
    assign {sc_w, frac_unused} = prod_w;

`ifdef MIX_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = vld_q
                  ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                     lfsr_q[15:1]}
                  : lfsr_q;
    assign tot_w = acc_d + $signed({{(AW-2){1'b0}}, lfsr_q[1:0]});

    // Dither LFSR steps once per frame, on the valid cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign tot_w = acc_d;
`endif

    // Mixer next-state: accumulate one voice per clock, emit at frame end.
    always_comb begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (phase_q == '0) acc_d = {{(AW-10){sc_w[9]}}, sc_w};
        else               acc_d = acc_q + {{(AW-10){sc_w[9]}}, sc_w};
        sh_w = tot_w >>> 2;
        if (sh_w > MAXV)      out_w = 8'hFF;
        else if (sh_w < MINV) out_w = 8'h00;
        else                  out_w = {~sh_w[7], sh_w[6:0]};
        mix_d = (phase_q == PH_LAST) ? out_w : mix_q;
        vld_d = (phase_q == PH_LAST);
    end

    // State registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pend_q  <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            mix_q   <= 8'h80;
            vld_q   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                lvl_q[v] <= 8'h00;
                st_q[v]  <= ST_IDLE;
            end
        end else begin
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            mix_q   <= mix_d;
            vld_q   <= vld_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                lvl_q[v] <= lvl_d[v];
                st_q[v]  <= st_d[v];
            end
        end
    end

    assign bus.mix_out   = mix_q;
    assign bus.mix_valid = vld_q;
endmodule

// File: tb/tb_voice_env_mixer.sv
// Bench for voice_env_mixer: spec-level model checked every cycle,
// plus directed literal expectations.
module tb_voice_env_mixer;
    localparam int NV = 4;
    localparam int TD = 4;
    localparam int AS = 2;
    localparam int RS = 3;
    localparam int S_IDLE = 0;
    localparam int S_ATT  = 1;
    localparam int S_SUS  = 2;
    localparam int S_REL  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    voice_env_mixer_if #(.NUM_VOICES(NV)) ifc();

    voice_env_mixer #(
        .NUM_VOICES(NV),
        .TICK_DIV(TD),
        .ATTACK_SHIFT(AS),
        .RELEASE_SHIFT(RS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          m_cyc;
    bit [NV-1:0] m_pend;
    int          m_lvl [NV];
    int          m_st  [NV];
    int          m_frame [NV];
    logic [7:0]  exp_m;
    logic        exp_v;
    logic [15:0] m_lfsr;
    int          hist0 [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int att(input int l);
        int n = l + ((255 - l) >> AS) + 1;
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int rel(input int l);
        int n = l - ((l >> RS) + 1);
        return (n < 0) ? 0 : n;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    // Model: cycle index since reset decides tick and voice slot.
    always @(posedge clk) begin
        int ph, s, tot, o, l, st;
        bit g;
        bit [NV-1:0] p;
        if (!rst_n) begin
            m_cyc  = 0;
            m_pend = '0;
            for (int v = 0; v < NV; v++) begin
                m_lvl[v] = 0;
                m_st[v]  = S_IDLE;
                m_frame[v] = 0;
            end
            exp_m  = 8'h80;
            exp_v  = 1'b0;
            m_lfsr = 16'hACE1;
        end else begin
            if (exp_v) m_lfsr = lfsr_next(m_lfsr);
            ph = m_cyc % NV;
            s  = int'(ifc.sample_in[8*ph +: 8]) - 128;
            m_frame[ph] = (s * m_lvl[ph]) >>> 8;
            exp_v = 1'b0;
            if (ph == NV - 1) begin
                tot = 0;
                for (int v = 0; v < NV; v++) tot += m_frame[v];
`ifdef MIX_DITHER_EN
                tot += int'(m_lfsr[1:0]);
`endif
                o = tot >>> 2;
                if (o > 127)  o = 127;
                if (o < -128) o = -128;
                exp_m = 8'(o + 128);
                exp_v = 1'b1;
            end
            p = m_pend | ifc.note_on;
            if ((m_cyc % TD) == TD - 1) begin
                for (int v = 0; v < NV; v++) begin
                    l = m_lvl[v];
                    st = m_st[v];
                    g = ifc.gate[v];
                    if (p[v] && g) begin
                        l = l >> 1;
                        st = S_ATT;
                    end else if (st == S_IDLE) begin
                        l = 0;
                        if (g) begin
                            l = att(0);
                            st = (l == 255) ? S_SUS : S_ATT;
                        end
                    end else if (st == S_ATT) begin
                        if (!g) st = S_REL;
                        else begin
                            l = att(l);
                            if (l == 255) st = S_SUS;
                        end
                    end else if (st == S_SUS) begin
                        l = 255;
                        if (!g) begin
                            l = rel(255);
                            st = (l == 0) ? S_IDLE : S_REL;
                        end
                    end else begin
                        if (g) st = S_ATT;
                        else begin
                            l = rel(l);
                            if (l == 0) st = S_IDLE;
                        end
                    end
                    m_lvl[v] = l;
                    m_st[v]  = st;
                end
                hist0.push_back(m_lvl[0]);
                m_pend = '0;
            end else begin
                m_pend = p;
            end
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mix_valid", {31'd0, ifc.mix_valid}, {31'd0, exp_v});
            check("mix_out", {24'd0, ifc.mix_out}, {24'd0, exp_m});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        hist0.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.mix_valid && n < 20);
        if (!ifc.mix_valid) check("wait_valid", 0, 1);
    endtask

    task automatic align_tick();
        while ((m_cyc % TD) != TD - 1) @(negedge clk);
    endtask

    initial begin
        int nval, bad, mono, top;
        rst_n = 1'b0;
        ifc.gate = '0;
        ifc.note_on = '0;
        ifc.sample_in = {NV{8'hFF}};
        cycles(3);
        chk_en = 1'b1;
        check("rst_mix_out", {24'd0, ifc.mix_out}, 32'h80);
        check("rst_valid", {31'd0, ifc.mix_valid}, 0);
        check("lfsr_pin", {16'd0, lfsr_next(16'hACE1)}, 32'h5670);
        rst_n = 1'b1;
        hist0.delete();

        nval = 0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifc.mix_valid) nval++;
            if (ifc.mix_out !== 8'h80) bad++;
        end
        check("t1_pulses", nval, 25);
        check("t1_idle_out", bad, 0);

        rst_n = 1'b0;
        ifc.gate = 4'b0001;
        cycles(2);
        hist0.delete();
        rst_n = 1'b1;
        cycles(100);
        check("t2_first", hist0[0], 64);
        check("t2_second", hist0[1], 112);
        mono = 1;
        top = 0;
        foreach (hist0[i]) begin
            if (i > 0 && hist0[i-1] < 255 && hist0[i] <= hist0[i-1])
                mono = 0;
            if (hist0[i] == 255) top = 1;
        end
        check("t2_monotonic", mono, 1);
        check("t2_reach_255", top, 1);
        check("t2_sustain", m_st[0], S_SUS);
        wait_valid();
        check("t2_mix", {24'd0, ifc.mix_out}, 32'h9F);

        ifc.gate = 4'b1111;
        cycles(100);
        wait_valid();
        check("t3_ff", {24'd0, ifc.mix_out}, 32'hFE);
        ifc.sample_in = {NV{8'h00}};
        cycles(8);
        wait_valid();
        check("t3_00", {24'd0, ifc.mix_out}, 32'h00);
        ifc.sample_in = {NV{8'h80}};
        cycles(8);
        wait_valid();
        check("t3_80", {24'd0, ifc.mix_out}, 32'h80);

        ifc.sample_in = {8'h80, 8'h80, 8'h80, 8'hFF};
        hist0.delete();
        ifc.gate = 4'b0000;
        cycles(300);
        check("t4_first", hist0[0], 223);
        mono = 1;
        foreach (hist0[i])
            if (i > 0 && hist0[i-1] > 0 && hist0[i] >= hist0[i-1])
                mono = 0;
        check("t4_monotonic", mono, 1);
        check("t4_floor", hist0[hist0.size()-1], 0);
        check("t4_idle", m_st[0], S_IDLE);
        wait_valid();
        check("t4_mix", {24'd0, ifc.mix_out}, 32'h80);

        ifc.gate = 4'b0001;
        cycles(100);
        align_tick();
        hist0.delete();
        ifc.note_on = 4'b0001;
        @(negedge clk);
        ifc.note_on = 4'b0000;
        cycles(4);
        check("t5_retrig", hist0[0], 127);
        check("t5_next", hist0[1], 160);

        cycles(100);
        ifc.sample_in = {NV{8'hFF}};
        align_tick();
        ifc.note_on = 4'b0010;
        @(negedge clk);
        ifc.note_on = 4'b0000;
        cycles(8);
        check("t5_gate_low_lvl", m_lvl[1], 0);
        check("t5_gate_low_st", m_st[1], S_IDLE);
        wait_valid();
        check("t5_gate_low_mix", {24'd0, ifc.mix_out}, 32'h9F);

        while ((m_cyc % TD) != 0) @(negedge clk);
        hist0.delete();
        ifc.note_on = 4'b0001;
        @(negedge clk);
        ifc.note_on = 4'b0000;
        cycles(4);
        check("t5_sticky", hist0[0], 127);

        while ((m_cyc % NV) != 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out", {24'd0, ifc.mix_out}, 32'h80);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifc.mix_valid !== 1'b0) bad++;
        end
        check("mid_rst_no_pulse", bad, 0);

`ifdef MIX_DITHER_EN
        ifc.gate = 4'b1111;
        ifc.sample_in = {NV{8'hFF}};
        do_reset();
        cycles(100);
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (ifc.mix_valid && ifc.mix_out != 8'hFE &&
                ifc.mix_out != 8'hFF) bad++;
        end
        check("t6_range", bad, 0);
`endif

        cycles(4);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
